// File: rtl/pattern_tx_pkg.sv
// Shared types and helpers for the serial pattern transmitter.
// State encoding, default timing parameters, counter sizing and bit-period math.
// Used by pattern_tx and its timer; holds no logic of its own.
package pattern_tx_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SETUP  = 3'd1,
      STROBE = 3'd2,
      GAP    = 3'd3,
      DONE   = 3'd4
   } state_t;

   localparam int TRIG_CYC_DEF = 1;
   localparam int GAP_CYC_DEF  = 5;

   // Width of the phase timer: it must hold max(TRIG_CYC, GAP_CYC).
   function automatic int cnt_width(input int trig_cyc, input int gap_cyc);
      int m;
      m = (trig_cyc > gap_cyc) ? trig_cyc : gap_cyc;
      return $clog2(m + 1);
   endfunction

   // Cycles spent on one bit: setup + strobe + gap.
   function automatic int bit_period(input int trig_cyc, input int gap_cyc);
      return 1 + trig_cyc + gap_cyc;
   endfunction

   localparam int CNT_W = cnt_width(TRIG_CYC_DEF, GAP_CYC_DEF);

endpackage

// File: rtl/pattern_tx_if.sv
// Request/serial bundle between a pattern source and pattern_tx.
// Pure wiring, no latency.
// Source may only start when ready is high; transmitter never stalls the detector.
interface pattern_tx_if #(
   parameter int WIDTH = 32
) ();
   localparam int LEN_W = $clog2(WIDTH + 1);

   logic             start;
   logic [WIDTH-1:0] pattern;
   logic [LEN_W-1:0] len;
   logic             abort;
   logic             ready;
   logic             busy;
   logic             done;
   logic             data;
   logic             trig;

   modport master (
      output start, pattern, len, abort,
      input  ready, busy, done, data, trig
   );

   modport slave (
      input  start, pattern, len, abort,
      output ready, busy, done, data, trig
   );
endinterface

// File: rtl/pattern_tx_timer.sv
// Loadable down-counter timing the STROBE and GAP phases.
// Load takes effect on the next edge; zero is a direct decode of the count.
// No backpressure: counts every cycle, holds at zero until reloaded.
module pattern_tx_timer #(
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [CNT_W-1:0] val,
   output logic             zero
);
   logic [CNT_W-1:0] cnt;

   // Reload on request, otherwise count down and park at zero.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         cnt <= '0;
      else if (load)
         cnt <= val;
      else if (cnt != '0)
         cnt <= cnt - CNT_W'(1);
   end

   assign zero = (cnt == '0);
endmodule

// File: rtl/pattern_tx.sv
// Serializes a latched pattern MSB-first as setup / trig strobe / gap per bit.
// len*(1+TRIG_CYC+GAP_CYC) cycles from accept to done; all outputs registered.
// start accepted only while ready; later starts are dropped, abort cancels.
module pattern_tx
   import pattern_tx_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int TRIG_CYC = TRIG_CYC_DEF,
   parameter int GAP_CYC  = GAP_CYC_DEF
) (
   input  logic        clk,
   input  logic        reset,
   pattern_tx_if.slave bus
);
   localparam int LEN_W = $clog2(WIDTH + 1);
   localparam int TW    = cnt_width(TRIG_CYC, GAP_CYC);
   localparam logic [TW-1:0] TRIG_LD = TW'(TRIG_CYC - 1);
   localparam logic [TW-1:0] GAP_LD  = TW'(GAP_CYC - 1);

   state_t           state, state_nxt;
   logic [WIDTH-1:0] sreg;
   logic [WIDTH-1:0] aligned;
   logic [WIDTH-1:0] shifted;
   logic [LEN_W-1:0] bit_cnt;
   logic             len_ok;
   logic             accept;
   logic             tmr_load;
   logic [TW-1:0]    tmr_val;
   logic             tmr_zero;

   logic ready_q, busy_q, done_q, trig_q, data_q;
   logic ready_n, busy_n, done_n, trig_n;

   assign len_ok  = (bus.len != '0) && (bus.len <= LEN_W'(WIDTH));
   assign accept  = (state == IDLE) && bus.start && len_ok;
   // Left-align so the first bit to send always sits at the MSB.
   assign aligned = bus.pattern << (LEN_W'(WIDTH) - bus.len);
   assign shifted = sreg << 1;

   pattern_tx_timer #(.CNT_W(TW)) u_timer (
      .clk   (clk),
      .reset (reset),
      .load  (tmr_load),
      .val   (tmr_val),
      .zero  (tmr_zero)
   );

   // State register plus the registered copies of the control outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         ready_q <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         trig_q  <= 1'b0;
      end else begin
         state   <= state_nxt;
         ready_q <= ready_n;
         busy_q  <= busy_n;
         done_q  <= done_n;
         trig_q  <= trig_n;
      end
   end

   // Next-state and timer control; abort overrides every non-idle transition.
   always_comb begin
      state_nxt = state;
      tmr_load  = 1'b0;
      tmr_val   = TRIG_LD;
      case (state)
         IDLE:   if (accept) state_nxt = SETUP;
         SETUP: begin
            state_nxt = STROBE;
            tmr_load  = 1'b1;
            tmr_val   = TRIG_LD;
         end
         STROBE: if (tmr_zero) begin
            state_nxt = GAP;
            tmr_load  = 1'b1;
            tmr_val   = GAP_LD;
         end
         GAP:    if (tmr_zero) state_nxt = (bit_cnt == LEN_W'(1)) ? DONE : SETUP;
         DONE:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (state != IDLE && bus.abort)
         state_nxt = IDLE;
   end

   // Output decode from the upcoming state so outputs line up with it after the edge.
   always_comb begin
      ready_n = (state_nxt == IDLE);
      busy_n  = (state_nxt != IDLE);
      done_n  = (state_nxt == DONE);
      trig_n  = (state_nxt == STROBE);
   end

   // Shift register, bit counter and data; data only moves when entering SETUP.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sreg    <= '0;
         bit_cnt <= '0;
         data_q  <= 1'b0;
      end else if (accept) begin
         sreg    <= aligned;
         bit_cnt <= bus.len;
         data_q  <= aligned[WIDTH-1];
      end else if (state == GAP && state_nxt == SETUP) begin
         sreg    <= shifted;
         bit_cnt <= bit_cnt - LEN_W'(1);
         data_q  <= shifted[WIDTH-1];
      end else if (state == GAP && state_nxt == DONE) begin
         bit_cnt <= bit_cnt - LEN_W'(1);
      end
   end

   assign bus.ready = ready_q;
   assign bus.busy  = busy_q;
   assign bus.done  = done_q;
   assign bus.trig  = trig_q;
   assign bus.data  = data_q;
endmodule

// File: tb/tb_pattern_tx.sv
// Randomized bench for pattern_tx with a cycle-arithmetic reference model.
// Two instances: default timing (1/5) and a swept timing (2/1).
// Outputs are sampled on the falling edge, inputs changed there too.
module tb_pattern_tx;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic        start, abort, sel;
   logic [31:0] pattern;
   logic [5:0]  len;

   pattern_tx_if #(.WIDTH(32)) bus1 ();
   pattern_tx_if #(.WIDTH(32)) bus2 ();

   assign bus1.start   = start & ~sel;
   assign bus1.abort   = abort & ~sel;
   assign bus1.pattern = pattern;
   assign bus1.len     = len;
   assign bus2.start   = start & sel;
   assign bus2.abort   = abort & sel;
   assign bus2.pattern = pattern;
   assign bus2.len     = len;

   pattern_tx #(.WIDTH(32), .TRIG_CYC(1), .GAP_CYC(5)) u_dut1 (
      .clk(clk), .reset(reset), .bus(bus1));
   pattern_tx #(.WIDTH(32), .TRIG_CYC(2), .GAP_CYC(1)) u_dut2 (
      .clk(clk), .reset(reset), .bus(bus2));

   logic o_ready, o_busy, o_done, o_data, o_trig;
   assign o_ready = sel ? bus2.ready : bus1.ready;
   assign o_busy  = sel ? bus2.busy  : bus1.busy;
   assign o_done  = sel ? bus2.done  : bus1.done;
   assign o_data  = sel ? bus2.data  : bus1.data;
   assign o_trig  = sel ? bus2.trig  : bus1.trig;

   int   n_chk  = 0;
   int   n_pass = 0;
   logic exp_hold [2];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // One transfer on instance s. ab_at/bs_at/rs_at: cycle offsets after accept for
   // abort, a start pulse while busy, and an async reset (-1 = none).
   task automatic run_xfer(input string name, input bit s, input logic [31:0] pat,
                           input int ln, input int ab_at, input int bs_at,
                           input int rs_at, input bit ab_with_start);
      int   t, g, p, budget, lim, stb_cnt, done_cnt, exp_stb, exp_done;
      bit   valid;
      logic prev_trig, e_data, e_trig, e_done, e_ready;
      t        = s ? 2 : 1;
      g        = s ? 1 : 5;
      p        = 1 + t + g;
      valid    = (ln >= 1) && (ln <= 32);
      budget   = valid ? ln * p + 3 : 4;
      lim      = (ab_at < 0) ? 32'h3fff_ffff : ab_at;
      stb_cnt  = 0;
      done_cnt = 0;
      prev_trig = 1'b0;
      sel     = s;
      pattern = pat;
      len     = 6'(ln);
      start   = 1'b1;
      abort   = ab_with_start;
      @(posedge clk);
      #1;
      start = 1'b0;
      abort = 1'b0;
      for (int c = 0; c < budget; c++) begin
         @(negedge clk);
         if (valid && c <= lim && c < ln * p) begin
            e_data = pat[ln - 1 - c / p];
            exp_hold[s] = e_data;
         end else begin
            e_data = exp_hold[s];
         end
         e_trig  = valid && c <= lim && c < ln * p && (c % p) >= 1 && (c % p) <= t;
         e_done  = valid && c <= lim && c == ln * p;
         e_ready = !(valid && c <= lim && c <= ln * p);
         chk($sformatf("%s c%0d data", name, c),  32'(o_data),  32'(e_data));
         chk($sformatf("%s c%0d trig", name, c),  32'(o_trig),  32'(e_trig));
         chk($sformatf("%s c%0d done", name, c),  32'(o_done),  32'(e_done));
         chk($sformatf("%s c%0d ready", name, c), 32'(o_ready), 32'(e_ready));
         chk($sformatf("%s c%0d busy", name, c),  32'(o_busy),  32'(!e_ready));
         if (o_trig && !prev_trig) stb_cnt++;
         prev_trig = o_trig;
         if (o_done) done_cnt++;
         if (c == rs_at) begin
            start = 1'b0;
            abort = 1'b0;
            reset = 1'b0;
            #1;
            chk({name, " rst trig"},  32'(o_trig),  32'd0);
            chk({name, " rst data"},  32'(o_data),  32'd0);
            chk({name, " rst ready"}, 32'(o_ready), 32'd1);
            chk({name, " rst busy"},  32'(o_busy),  32'd0);
            chk({name, " rst done"},  32'(o_done),  32'd0);
            repeat (2) @(negedge clk);
            reset = 1'b1;
            exp_hold[0] = 1'b0;
            exp_hold[1] = 1'b0;
            return;
         end
         start = (c == bs_at);
         if (c == bs_at) pattern = ~pat;
         abort = (c == ab_at);
      end
      start = 1'b0;
      abort = 1'b0;
      exp_stb = 0;
      for (int i = 0; i < ln; i++)
         if (valid && 1 + i * p <= lim) exp_stb++;
      exp_done = (valid && ln * p <= lim) ? 1 : 0;
      chk({name, " strobes"},  32'(stb_cnt),  32'(exp_stb));
      chk({name, " done_cnt"}, 32'(done_cnt), 32'(exp_done));
   endtask

   initial begin
      int ln, p, ab, bs;
      bit s;
      reset   = 1'b0;
      start   = 1'b1;
      abort   = 1'b0;
      sel     = 1'b0;
      pattern = 32'h7f;
      len     = 6'd7;
      exp_hold[0] = 1'b0;
      exp_hold[1] = 1'b0;

      // Held in reset with start asserted: nothing may move.
      repeat (11) begin
         @(negedge clk);
         chk("reset ready", 32'(o_ready), 32'd1);
         chk("reset busy",  32'(o_busy),  32'd0);
         chk("reset trig",  32'(o_trig),  32'd0);
         chk("reset data",  32'(o_data),  32'd0);
         chk("reset ready2", 32'(bus2.ready), 32'd1);
      end
      start = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("post-reset ready", 32'(o_ready), 32'd1);
         chk("post-reset busy",  32'(o_busy),  32'd0);
      end

      run_xfer("detseq",   0, 32'b0010111,   7,  -1, -1, -1, 0);
      run_xfer("len1",     0, 32'h1,         1,  -1, -1, -1, 0);
      run_xfer("len32",    0, 32'hA5A5_0F0F, 32, -1, -1, -1, 0);
      run_xfer("len0",     0, 32'hFFFF_FFFF, 0,  -1, -1, -1, 0);
      run_xfer("len33",    0, 32'hFFFF_FFFF, 33, -1, -1, -1, 0);
      run_xfer("sweep",    1, 32'b101,       3,  -1, -1, -1, 0);
      run_xfer("abort",    0, 32'h35,        6,  8,  -1, -1, 0);
      run_xfer("busystart",0, 32'h2D,        6,  -1, 10, -1, 0);
      run_xfer("abortstart",0, 32'h5,        3,  -1, -1, -1, 1);
      run_xfer("midreset", 0, 32'h5A,        8,  -1, -1, 17, 0);
      run_xfer("afterrst", 0, 32'hC3,        8,  -1, -1, -1, 0);

      for (int k = 0; k < 24; k++) begin
         s  = $urandom_range(0, 1) == 1;
         p  = s ? 4 : 7;
         ln = ($urandom_range(0, 7) == 0) ? (($urandom_range(0, 1) == 1) ? 33 : 0)
                                          : $urandom_range(1, 32);
         ab = -1;
         bs = -1;
         if (ln >= 1 && ln <= 32) begin
            if ($urandom_range(0, 3) == 0) ab = $urandom_range(0, ln * p);
            if ($urandom_range(0, 3) == 0) begin
               bs = $urandom_range(0, ln * p);
               if (ab >= 0 && bs > ab) bs = ab;
            end
         end
         run_xfer($sformatf("rnd%0d", k), s, $urandom, ln, ab, bs, -1, 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/pattern_tx.md
Name: pattern_tx

Overview:
- Serial pattern transmitter feeding the fsm pattern detector. It drives the detector's `data`/`trig` pair.
- Loads a parallel bit pattern of up to WIDTH bits and serializes it MSB-first.
- Each bit is presented on `data` with a setup cycle, then a `trig` strobe, then a hold gap.
- Replaces hand-written stimulus tasks in system-level benches and on-board self-test.

Parameters:
- WIDTH, 32, maximum pattern length in bits (>=1).
- TRIG_CYC, 1, cycles `trig` is held high per bit (>=1).
- GAP_CYC, 5, cycles `trig` is low after the strobe while `data` is held (>=1).
- LEN_W, $clog2(WIDTH+1), width of the length field (derived; not overridden).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous active-low reset (0 = reset asserted)
- start  in  1  request to send; sampled only when ready=1
- pattern  in  WIDTH  bits to send; bit [len-1] is sent first, bit 0 last
- len  in  LEN_W  number of bits to send (1..WIDTH)
- abort  in  1  synchronous cancel of the transfer in progress
- ready  out  1  high in IDLE; a start will be accepted
- busy  out  1  high while a transfer is in progress
- done  out  1  one-cycle pulse after the last bit's gap completes
- data  out  1  serial bit to the detector
- trig  out  1  strobe to the detector; `data` is stable whenever trig=1

Behaviour:
- Reset (reset=0, asynchronous): go to IDLE; ready=1, busy=0, done=0, data=0, trig=0; shift register and counters cleared.
- Accept rule: on a clk edge with state=IDLE, start=1 and 1<=len<=WIDTH, latch pattern and len, then enter SETUP.
  - start with len=0 or len>WIDTH is ignored: stay IDLE, no done.
  - start while busy is ignored and is not queued.
- States:
  - IDLE: ready=1, busy=0, trig=0; data holds its last value.
  - SETUP (1 cycle): data = current bit, trig=0. Goes to STROBE.
  - STROBE (TRIG_CYC cycles): trig=1, data unchanged. Goes to GAP.
  - GAP (GAP_CYC cycles): trig=0, data unchanged. Then:
    - if bits remain, go to SETUP with the next bit;
    - otherwise go to DONE.
  - DONE (1 cycle): done=1, busy=1, trig=0. Goes to IDLE.
- Timing:
  - Per-bit period = 1 + TRIG_CYC + GAP_CYC cycles.
  - Total from the accept edge to the done pulse = len*(1+TRIG_CYC+GAP_CYC) cycles; done is high in the cycle after that.
  - `data` changes only on entry to SETUP, so the detector never sees a data edge while trig=1.
- busy=1 in SETUP, STROBE, GAP and DONE; ready = (state==IDLE).
- Bit order: the left-aligned shift register shifts left on each SETUP entry after the first; a bit counter counts down from len to 0.
- Abort: abort=1 in any non-IDLE state returns to IDLE on the next edge.
  - trig=0 from that cycle; no done pulse; data holds its value.
  - abort in IDLE has no effect.
  - abort together with start in IDLE: start is accepted and abort is ignored.
- Reset mid-transfer: trig and data drop to 0 immediately (asynchronous). No done pulse.
- All outputs are registered, with no combinational path from inputs to outputs.

Decomposition:
- Package `pattern_tx_pkg`:
  - state enum {IDLE, SETUP, STROBE, GAP, DONE};
  - localparam CNT_W = $clog2(max(TRIG_CYC, GAP_CYC)+1);
  - helper function for the per-bit period.
- Sub-module `pattern_tx_timer`: loadable down-counter with a `zero` flag, clk/reset with the same async active-low reset. It serves both the STROBE and GAP phases. The bit counter and shift register stay in the top.

Test Plan:
1. Reset: hold reset=0 for 11 cycles while start=1 -> ready=1, busy=0, trig=0, data=0 throughout; release -> ready=1 and no transfer begins until start is sampled after release.
2. Detector sequence, defaults: pattern=7'b0010111, len=7 -> data sequence 0,0,1,0,1,1,1; exactly 7 trig pulses, each 1 cycle, spaced 7 cycles apart; done pulses 49 cycles after accept; data never toggles while trig=1.
3. Length boundaries, WIDTH=32:
   - len=1, pattern bit0=1 -> one trig, data=1, done after 7 cycles;
   - len=32 with pattern=32'hA5A5_0F0F -> 32 strobes, MSB first;
   - len=0 and len=33 -> ignored, ready stays 1, no done.
4. Parameter sweep TRIG_CYC=2, GAP_CYC=1: len=3, pattern=3'b101 -> trig high 2 cycles per bit, period 4, done at cycle 12.
5. Abort/overlap:
   - assert abort during the second bit's STROBE -> trig low next cycle, ready=1, no done;
   - start pulsed while busy -> ignored, the original transfer completes unchanged.
6. Reset mid-transfer during GAP of bit 3 -> outputs cleared immediately; a new start after release sends the new pattern from its MSB.
